// File: rtl/mavg_pkg.sv
// Shared types and helpers for the multi-channel moving-average accumulator.
// Default widths here also size the tagged sample struct used by the pipeline.
package mavg_pkg;

   localparam int DATA_WIDTH_DEF = 10;
   localparam int ACC_POW_DEF    = 7;
   localparam int CHANNELS_DEF   = 4;

   function automatic int ch_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

   function automatic int acc_width(input int data_width, input int acc_pow);
      return data_width + acc_pow;
   endfunction

   // Window exponents above the ring depth fall back to the full ring.
   function automatic int clamp_pow(input int wp, input int max_pow);
      return (wp > max_pow) ? max_pow : wp;
   endfunction

   localparam int CH_W_DEF = ch_width(CHANNELS_DEF);

   typedef struct packed {
      logic [CH_W_DEF-1:0]       chan;
      logic [DATA_WIDTH_DEF-1:0] data;
   } sample_t;

endpackage

// File: rtl/mavg_if.sv
// Sample-in / result-out bundle between the ADC mux, the accumulator and the
// per-axis filters.
interface mavg_if
   import mavg_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ACC_POW    = ACC_POW_DEF,
   parameter int CHANNELS   = CHANNELS_DEF,
   parameter int CH_W       = ch_width(CHANNELS)
);

   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, ACC_POW);

   logic                  valid_in;
   logic [CH_W-1:0]       chan_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  valid_out;
   logic [CH_W-1:0]       chan_out;
   logic [ACC_WIDTH-1:0]  data_out;
   logic                  primed_out;

   modport master (
      output valid_in, chan_in, data_in,
      input  valid_out, chan_out, data_out, primed_out
   );

   modport slave (
      input  valid_in, chan_in, data_in,
      output valid_out, chan_out, data_out, primed_out
   );

endinterface

// File: rtl/mavg_ring_ram.sv
// Simple dual-port sample ring: one registered read, one write, read-before-write
// when both ports hit the same address in the same cycle.
module mavg_ring_ram #(
   parameter int DATA_WIDTH = 10,
   parameter int DEPTH      = 512,
   parameter int AW         = 9
)(
   input  logic                  clock,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Non-blocking read and write on the same edge give the pre-write contents.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/mavg_mc.sv
// Multi-channel sliding-window accumulator: per-channel sum of the last 2^win_pow
// samples from a tagged, time-multiplexed stream, two-cycle latency, no stalls.
module mavg_mc
   import mavg_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ACC_POW    = ACC_POW_DEF,
   parameter int CHANNELS   = CHANNELS_DEF,
   parameter int CH_W       = ch_width(CHANNELS),
   parameter int WP_W       = $clog2(ACC_POW + 1)
)(
   input  logic            clock,
   input  logic            sclr,
   input  logic [WP_W-1:0] win_pow,
   input  logic            avg_en,
   mavg_if.slave           bus
);

   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, ACC_POW);
   localparam int AW        = CH_W + ACC_POW;
   localparam int DEPTH     = CHANNELS << ACC_POW;

   logic [WP_W-1:0]       win_pow_q;
   logic [WP_W-1:0]       win_pow_c;
   logic                  cfg_change;
   logic                  in_range;
   logic                  accept;
   logic [CH_W-1:0]       in_chan;
   logic [ACC_POW:0]      win_len;

   logic [ACC_POW-1:0]    wr_ptr [CHANNELS];
   logic [ACC_POW:0]      fill   [CHANNELS];
   logic [ACC_WIDTH-1:0]  acc    [CHANNELS];

   logic [AW-1:0]         wr_addr;
   logic [AW-1:0]         rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;

   logic                  s1_valid;
   sample_t               s1_smp;
   logic                  full;
   logic [ACC_WIDTH-1:0]  acc_cur;
   logic [ACC_WIDTH-1:0]  old_term;
   logic [ACC_WIDTH-1:0]  acc_next;
   logic [ACC_POW:0]      fill_cur;
   logic [ACC_POW:0]      fill_next;

   // Stage 0: accept decision and ring addressing; the read slot is the one
   // leaving the window, 2^win_pow entries behind the write slot.
   always_comb begin
      win_pow_c  = WP_W'(clamp_pow(32'(win_pow), ACC_POW));
      cfg_change = (win_pow_c != win_pow_q);
      in_range   = (32'(bus.chan_in) < 32'(CHANNELS));
      in_chan    = in_range ? bus.chan_in : '0;
      accept     = bus.valid_in && in_range && !cfg_change && !sclr;
      win_len    = (ACC_POW + 1)'(1) << win_pow_q;
      wr_addr    = {in_chan, wr_ptr[in_chan]};
      rd_addr    = {in_chan, wr_ptr[in_chan] - win_len[ACC_POW-1:0]};
   end

   mavg_ring_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_ring (
      .clock   (clock),
      .wr_en   (accept),
      .wr_addr (wr_addr),
      .wr_data (bus.data_in),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Stage 1: the acc/fill arrays are read and written back in this same stage,
   // so a back-to-back sample on one channel already sees the previous result.
   always_comb begin
      acc_cur   = acc[s1_smp.chan];
      fill_cur  = fill[s1_smp.chan];
      full      = (fill_cur >= win_len);
      old_term  = full ? ACC_WIDTH'(rd_data) : '0;
      acc_next  = acc_cur + ACC_WIDTH'(s1_smp.data) - old_term;
      fill_next = full ? fill_cur : fill_cur + (ACC_POW + 1)'(1);
   end

   // A window change behaves like a clear of all channel state and in-flight work.
   always_ff @(posedge clock) begin
      if (sclr || cfg_change) begin
         win_pow_q <= win_pow_c;
         s1_valid  <= 1'b0;
         s1_smp    <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            acc[c]    <= '0;
            fill[c]   <= '0;
            wr_ptr[c] <= '0;
         end
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_smp.chan     <= bus.chan_in;
            s1_smp.data     <= bus.data_in;
            wr_ptr[in_chan] <= wr_ptr[in_chan] + ACC_POW'(1);
         end
         if (s1_valid) begin
            acc[s1_smp.chan]  <= acc_next;
            fill[s1_smp.chan] <= fill_next;
         end
      end
   end

   // Stage 2: result register; data fields hold between strobes.
   always_ff @(posedge clock) begin
      if (sclr) begin
         bus.valid_out  <= 1'b0;
         bus.chan_out   <= '0;
         bus.data_out   <= '0;
         bus.primed_out <= 1'b0;
      end else begin
         bus.valid_out <= s1_valid && !cfg_change;
         if (s1_valid && !cfg_change) begin
            bus.chan_out   <= s1_smp.chan;
            bus.data_out   <= avg_en ? (acc_next >> win_pow_q) : acc_next;
            bus.primed_out <= (fill_next == win_len);
         end
      end
   end

endmodule

// File: tb/tb_mavg_mc.sv
// Self-checking bench for mavg_mc: directed scenarios plus a random stream,
// all compared against a per-channel sample-history model of the window sums.
module tb_mavg_mc;
   import mavg_pkg::*;

   localparam int DATA_WIDTH = 10;
   localparam int ACC_POW    = 7;
   localparam int CHANNELS   = 4;
   localparam int CH_W       = ch_width(CHANNELS);
   localparam int WP_W       = $clog2(ACC_POW + 1);
   localparam int HIST_DEPTH = 4096;
   localparam int MAX_DATA   = (1 << DATA_WIDTH) - 1;

   logic            clock = 1'b0;
   logic            sclr;
   logic [WP_W-1:0] win_pow;
   logic            avg_en;

   mavg_if #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_POW    (ACC_POW),
      .CHANNELS   (CHANNELS),
      .CH_W       (CH_W)
   ) bus ();

   mavg_mc #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_POW    (ACC_POW),
      .CHANNELS   (CHANNELS),
      .CH_W       (CH_W),
      .WP_W       (WP_W)
   ) dut (
      .clock   (clock),
      .sclr    (sclr),
      .win_pow (win_pow),
      .avg_en  (avg_en),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int     n_compared   = 0;
   int     n_mismatched = 0;

   // Reference model: every accepted sample since the last clear, per channel.
   int     hist [CHANNELS][HIST_DEPTH];
   int     cnt  [CHANNELS];
   int     cur_wp;
   bit     pend_v;
   int     pend_ch;
   longint pend_sum;
   bit     pend_primed;

   task automatic check_output(input string tag, input longint got, input longint exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int c = 0; c < CHANNELS; c++) cnt[c] = 0;
      pend_v = 1'b0;
   endtask

   // One clock: drive inputs, let the edge pass, then compare what became visible.
   task automatic apply_stimulus(input bit v, input int ch, input int d,
                                 input int wp, input bit ae, input bit rst);
      int     wp_c;
      int     len;
      int     n;
      longint sum;
      bus.valid_in = v;
      bus.chan_in  = CH_W'(ch);
      bus.data_in  = DATA_WIDTH'(d);
      win_pow      = WP_W'(wp);
      avg_en       = ae;
      sclr         = rst;
      @(posedge clock);
      #1;
      wp_c = (wp > ACC_POW) ? ACC_POW : wp;
      if (rst) begin
         clear_model();
         cur_wp = wp_c;
         check_output("rst_valid", longint'(bus.valid_out), 0);
         check_output("rst_chan", longint'(bus.chan_out), 0);
         check_output("rst_data", longint'(bus.data_out), 0);
         check_output("rst_primed", longint'(bus.primed_out), 0);
      end else if (wp_c != cur_wp) begin
         clear_model();
         cur_wp = wp_c;
         check_output("cfg_valid", longint'(bus.valid_out), 0);
      end else begin
         if (pend_v) begin
            check_output("valid_out", longint'(bus.valid_out), 1);
            check_output("chan_out", longint'(bus.chan_out), longint'(pend_ch));
            check_output("data_out", longint'(bus.data_out),
                         ae ? (pend_sum >> cur_wp) : pend_sum);
            check_output("primed_out", longint'(bus.primed_out), longint'(pend_primed));
         end else begin
            check_output("idle_valid", longint'(bus.valid_out), 0);
         end
         if (v && (ch % (1 << CH_W)) < CHANNELS) begin
            ch = ch % (1 << CH_W);
            hist[ch][cnt[ch] % HIST_DEPTH] = d;
            cnt[ch]++;
            len = 1 << cur_wp;
            n   = (cnt[ch] < len) ? cnt[ch] : len;
            sum = 0;
            for (int i = 0; i < n; i++) sum += longint'(hist[ch][(cnt[ch] - 1 - i) % HIST_DEPTH]);
            pend_v      = 1'b1;
            pend_ch     = ch;
            pend_sum    = sum;
            pend_primed = (cnt[ch] >= len);
         end else begin
            pend_v = 1'b0;
         end
      end
   endtask

   initial begin
      bit r_ae;
      int r_wp;
      bus.valid_in = 1'b0;
      bus.chan_in  = '0;
      bus.data_in  = '0;
      win_pow      = WP_W'(2);
      avg_en       = 1'b0;
      sclr         = 1'b1;
      clear_model();
      cur_wp = 2;

      apply_stimulus(0, 0, 0, 2, 0, 1);
      apply_stimulus(0, 0, 0, 2, 0, 1);

      // Constant 5 on one channel, raw sum then average.
      for (int i = 0; i < 8; i++) apply_stimulus(1, 0, 5, 2, 0, 0);
      apply_stimulus(0, 0, 0, 2, 0, 0);
      check_output("five_sum", longint'(bus.data_out), 20);
      check_output("five_primed", longint'(bus.primed_out), 1);
      for (int i = 0; i < 4; i++) apply_stimulus(1, 0, 5, 2, 1, 0);
      apply_stimulus(0, 0, 0, 2, 1, 0);
      check_output("five_avg", longint'(bus.data_out), 5);

      // Ramp 1..6 into a 4-deep window.
      apply_stimulus(0, 0, 0, 2, 0, 1);
      for (int i = 1; i <= 6; i++) apply_stimulus(1, 0, i, 2, 0, 0);
      apply_stimulus(0, 0, 0, 2, 0, 0);
      check_output("ramp_sum", longint'(bus.data_out), 18);

      // Back-to-back same-channel samples between other channels' traffic.
      apply_stimulus(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) apply_stimulus(1, 1 + (i % 2), 30 + i, 1, 0, 0);
      for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 7, 1, 0, 0);
      apply_stimulus(1, 1, 40, 1, 0, 0);
      check_output("fwd_chan", longint'(bus.chan_out), 0);
      check_output("fwd_sum", longint'(bus.data_out), 14);
      apply_stimulus(0, 0, 0, 1, 0, 0);

      // Full-depth window of all-ones: read and write hit the same slot.
      apply_stimulus(0, 0, 0, ACC_POW, 0, 0);
      for (int i = 0; i < (1 << ACC_POW) + 3; i++) apply_stimulus(1, 2, MAX_DATA, ACC_POW, 0, 0);
      apply_stimulus(0, 0, 0, ACC_POW, 0, 0);
      check_output("sat_sum", longint'(bus.data_out), longint'(MAX_DATA) << ACC_POW);
      check_output("sat_primed", longint'(bus.primed_out), 1);
      apply_stimulus(1, 2, MAX_DATA, ACC_POW, 1, 0);
      apply_stimulus(0, 0, 0, ACC_POW, 1, 0);
      check_output("sat_avg", longint'(bus.data_out), longint'(MAX_DATA));

      // Window change in mid-stream.
      apply_stimulus(0, 0, 0, 2, 0, 0);
      for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 3, 2, 0, 0);
      apply_stimulus(1, 0, 9, 3, 0, 0);
      apply_stimulus(1, 0, 11, 3, 0, 0);
      apply_stimulus(0, 0, 0, 3, 0, 0);
      check_output("cfg_restart_sum", longint'(bus.data_out), 11);
      check_output("cfg_restart_primed", longint'(bus.primed_out), 0);

      // Clear with two samples in flight.
      apply_stimulus(1, 1, 100, 3, 0, 0);
      apply_stimulus(1, 1, 200, 3, 0, 0);
      apply_stimulus(1, 1, 50, 3, 0, 1);
      apply_stimulus(0, 0, 0, 3, 0, 0);
      apply_stimulus(0, 0, 0, 3, 0, 0);
      apply_stimulus(1, 3, 321, 3, 0, 0);
      apply_stimulus(0, 0, 0, 3, 0, 0);
      check_output("post_clr_sum", longint'(bus.data_out), 321);

      // Random traffic with occasional window, mode and reset changes.
      r_wp = 3;
      r_ae = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 199) == 0) r_wp = int'($urandom_range(0, ACC_POW));
         if ($urandom_range(0, 49) == 0) r_ae = ~r_ae;
         apply_stimulus($urandom_range(0, 9) < 7,
                        int'($urandom_range(0, (1 << CH_W) - 1)),
                        int'($urandom_range(0, MAX_DATA)),
                        r_wp, r_ae, $urandom_range(0, 299) == 0);
      end
      apply_stimulus(0, 0, 0, r_wp, r_ae, 0);
      apply_stimulus(0, 0, 0, r_wp, r_ae, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
